// File: rtl/memory_window_align.sv
// memory_window_align
//
// Sits between the line-buffer SRAM bank and the block-matching datapath and
// extracts a column window from the beats it receives. Each accepted beat
// holds one pixel column from every SRAM line. The beat is rotated by the
// circular head pointer so that window row 0 comes first. It is then pushed
// into a REG_NUM-deep column delay line. Three co-centred columns are taken
// from that line: the newest reference column, the mid-window search column
// and the oldest total column.
//
// Ports:
//   clk          clock
//   rst_n        asynchronous active-low reset
//   valid_i      beat strobe; data_i / head_num_i are sampled only when high
//   sof_i        start of row sweep; clears the fill count and the error flag
//   data_i       NUM_LINES pixels, line j at [j*DATA_WIDTH +: DATA_WIDTH]
//   head_num_i   SRAM line that holds window row 0
//   total_blk_o  oldest column, TOTAL_LENGTH rows, row 0 at the LSBs
//   srh_blk_o    middle SRH_LENGTH rows of the search column
//   ref_blk_o    middle REF_LENGTH rows of the newest column
//   valid_o      output columns are valid this cycle
//   head_err_o   sticky flag, set when a head >= NUM_LINES is seen on a beat
//
// Build option:
//   MEMORY_WINDOW_ALIGN_OUTREG_EN  adds one register stage on the three block
//                                  outputs and valid_o, so latency grows from
//                                  t+1 to t+2. head_err_o is not delayed.

module memory_window_align #(
    parameter int NUM_LINES    = 18,
    parameter int TOTAL_LENGTH = 17,
    parameter int SRH_LENGTH   = 13,
    parameter int REF_LENGTH   = 5,
    parameter int DATA_WIDTH   = 12,
    parameter int HEAD_WIDTH   = 5
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               valid_i,
    input  logic                               sof_i,
    input  logic [NUM_LINES*DATA_WIDTH-1:0]    data_i,
    input  logic [HEAD_WIDTH-1:0]              head_num_i,
    output logic [TOTAL_LENGTH*DATA_WIDTH-1:0] total_blk_o,
    output logic [SRH_LENGTH*DATA_WIDTH-1:0]   srh_blk_o,
    output logic [REF_LENGTH*DATA_WIDTH-1:0]   ref_blk_o,
    output logic                               valid_o,
    output logic                               head_err_o
);

    localparam int REG_NUM    = (TOTAL_LENGTH - REF_LENGTH) / 2 + 1;
    localparam int TOTAL_REF  = (TOTAL_LENGTH - REF_LENGTH) / 2;
    localparam int TOTAL_SRH  = (TOTAL_LENGTH - SRH_LENGTH) / 2;
    localparam int SRH_REF    = (SRH_LENGTH - REF_LENGTH) / 2;
    localparam int COL_W      = TOTAL_LENGTH * DATA_WIDTH;
    localparam int CNT_W      = $clog2(REG_NUM + 1);
    localparam int LINE_SLOTS = 1 << HEAD_WIDTH;

    // The line array is padded to a power of two. A HEAD_WIDTH-bit index then
    // always lands inside it, and the padding slots are never selected
    // because the wrapped index is always below NUM_LINES.
    logic [DATA_WIDTH-1:0] line_w [LINE_SLOTS];

    for (genvar g = 0; g < LINE_SLOTS; g++) begin : g_line
        if (g < NUM_LINES) begin : g_used
            assign line_w[g] = data_i[g*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_pad
            assign line_w[g] = '0;
        end
    end

    // Compare one bit wider so that NUM_LINES == 2^HEAD_WIDTH still works.
    logic                  head_bad;
    logic [HEAD_WIDTH-1:0] head_eff;

    assign head_bad = ({1'b0, head_num_i} >= (HEAD_WIDTH+1)'(NUM_LINES));
    assign head_eff = head_bad ? '0 : head_num_i;

    // head < NUM_LINES and i < TOTAL_LENGTH < NUM_LINES, so head+i is below
    // 2*NUM_LINES. A single conditional subtract therefore wraps it.
    logic [COL_W-1:0]  rot_col;
    logic [HEAD_WIDTH:0] row_idx;

    always_comb begin
        rot_col = '0;
        row_idx = '0;
        for (int i = 0; i < TOTAL_LENGTH; i++) begin
            row_idx = {1'b0, head_eff} + (HEAD_WIDTH+1)'(i);
            if (row_idx >= (HEAD_WIDTH+1)'(NUM_LINES)) begin
                row_idx = row_idx - (HEAD_WIDTH+1)'(NUM_LINES);
            end
            rot_col[i*DATA_WIDTH +: DATA_WIDTH] = line_w[row_idx[HEAD_WIDTH-1:0]];
        end
    end

    logic [COL_W-1:0] col_q [REG_NUM];
    logic [COL_W-1:0] col_d [REG_NUM];

    always_comb begin
        for (int k = 0; k < REG_NUM; k++) begin
            col_d[k] = col_q[k];
        end
        if (valid_i) begin
            col_d[0] = rot_col;
            for (int k = 1; k < REG_NUM; k++) begin
                col_d[k] = col_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < REG_NUM; k++) begin
                col_q[k] <= '0;
            end
        end else begin
            col_q <= col_d;
        end
    end

    logic [CNT_W-1:0] fill_q, fill_d;
    logic             valid_q, valid_d;
    logic             head_err_q, head_err_d;

    always_comb begin
        fill_d = fill_q;
        if (sof_i && valid_i) begin
            fill_d = CNT_W'(1);
        end else if (sof_i) begin
            fill_d = '0;
        end else if (valid_i && (fill_q != CNT_W'(REG_NUM))) begin
            fill_d = fill_q + 1'b1;
        end

        valid_d = valid_i && (fill_d == CNT_W'(REG_NUM));

        // The clear is applied first, so an erroneous beat in the same
        // cycle as sof_i still sets the flag.
        head_err_d = head_err_q;
        if (sof_i) begin
            head_err_d = 1'b0;
        end
        if (valid_i && head_bad) begin
            head_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q     <= '0;
            valid_q    <= 1'b0;
            head_err_q <= 1'b0;
        end else begin
            fill_q     <= fill_d;
            valid_q    <= valid_d;
            head_err_q <= head_err_d;
        end
    end

    assign head_err_o = head_err_q;

`ifdef MEMORY_WINDOW_ALIGN_OUTREG_EN
    logic [COL_W-1:0]                 total_out_q, total_out_d;
    logic [SRH_LENGTH*DATA_WIDTH-1:0] srh_out_q, srh_out_d;
    logic [REF_LENGTH*DATA_WIDTH-1:0] ref_out_q, ref_out_d;
    logic                             valid_out_q, valid_out_d;

    always_comb begin
        total_out_d = col_q[REG_NUM-1];
        srh_out_d   = col_q[SRH_REF][TOTAL_SRH*DATA_WIDTH +: SRH_LENGTH*DATA_WIDTH];
        ref_out_d   = col_q[0][TOTAL_REF*DATA_WIDTH +: REF_LENGTH*DATA_WIDTH];
        valid_out_d = valid_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_out_q <= '0;
            srh_out_q   <= '0;
            ref_out_q   <= '0;
            valid_out_q <= 1'b0;
        end else begin
            total_out_q <= total_out_d;
            srh_out_q   <= srh_out_d;
            ref_out_q   <= ref_out_d;
            valid_out_q <= valid_out_d;
        end
    end

    assign total_blk_o = total_out_q;
    assign srh_blk_o   = srh_out_q;
    assign ref_blk_o   = ref_out_q;
    assign valid_o     = valid_out_q;
`else
    assign total_blk_o = col_q[REG_NUM-1];
    assign srh_blk_o   = col_q[SRH_REF][TOTAL_SRH*DATA_WIDTH +: SRH_LENGTH*DATA_WIDTH];
    assign ref_blk_o   = col_q[0][TOTAL_REF*DATA_WIDTH +: REF_LENGTH*DATA_WIDTH];
    assign valid_o     = valid_q;
`endif

endmodule

// File: tb/tb_memory_window_align.sv
// Self-checking bench for memory_window_align. A behavioural model keeps the
// history of rotated beats and a count of beats since start-of-sweep. A
// negedge compare process checks every output against it, and directed
// sections pin the model with hand-computed values.

module tb_memory_window_align;

    localparam int NUM_LINES    = 18;
    localparam int TOTAL_LENGTH = 17;
    localparam int SRH_LENGTH   = 13;
    localparam int REF_LENGTH   = 5;
    localparam int DW           = 12;
    localparam int HEAD_WIDTH   = 5;
    localparam int REG_NUM      = (TOTAL_LENGTH - REF_LENGTH) / 2 + 1;
    localparam int TOTAL_REF    = (TOTAL_LENGTH - REF_LENGTH) / 2;
    localparam int TOTAL_SRH    = (TOTAL_LENGTH - SRH_LENGTH) / 2;
    localparam int SRH_REF      = (SRH_LENGTH - REF_LENGTH) / 2;
    localparam int COL_W        = TOTAL_LENGTH * DW;
    localparam int IN_W         = NUM_LINES * DW;
`ifdef MEMORY_WINDOW_ALIGN_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic                       clk;
    logic                       rst_n;
    logic                       valid_i;
    logic                       sof_i;
    logic [IN_W-1:0]            data_i;
    logic [HEAD_WIDTH-1:0]      head_num_i;
    logic [COL_W-1:0]           total_blk_o;
    logic [SRH_LENGTH*DW-1:0]   srh_blk_o;
    logic [REF_LENGTH*DW-1:0]   ref_blk_o;
    logic                       valid_o;
    logic                       head_err_o;

    memory_window_align #(
        .NUM_LINES(NUM_LINES), .TOTAL_LENGTH(TOTAL_LENGTH), .SRH_LENGTH(SRH_LENGTH),
        .REF_LENGTH(REF_LENGTH), .DATA_WIDTH(DW), .HEAD_WIDTH(HEAD_WIDTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .sof_i(sof_i),
        .data_i(data_i), .head_num_i(head_num_i),
        .total_blk_o(total_blk_o), .srh_blk_o(srh_blk_o), .ref_blk_o(ref_blk_o),
        .valid_o(valid_o), .head_err_o(head_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [COL_W-1:0] act, input logic [COL_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [COL_W-1:0] hist [$];   // hist[k] = rotated beat accepted k beats ago
    int               m_fill;     // beats since the last start-of-sweep
    logic             m_valid;
    logic             m_err;
    logic [COL_W-1:0] o_total, o_srh, o_ref;
    logic             o_valid;

    function automatic logic [COL_W-1:0] rotate(input logic [IN_W-1:0] d, input int h);
        logic [COL_W-1:0] c;
        c = '0;
        for (int i = 0; i < TOTAL_LENGTH; i++) begin
            c[i*DW +: DW] = d[((h + i) % NUM_LINES)*DW +: DW];
        end
        return c;
    endfunction

    function automatic logic [COL_W-1:0] s1_total();
        return hist[REG_NUM-1];
    endfunction

    function automatic logic [COL_W-1:0] s1_srh();
        logic [COL_W-1:0] t;
        t = hist[SRH_REF];
        return COL_W'(t[TOTAL_SRH*DW +: SRH_LENGTH*DW]);
    endfunction

    function automatic logic [COL_W-1:0] s1_ref();
        logic [COL_W-1:0] t;
        t = hist[0];
        return COL_W'(t[TOTAL_REF*DW +: REF_LENGTH*DW]);
    endfunction

    function automatic logic [COL_W-1:0] e_total();
        return (LAT == 2) ? o_total : s1_total();
    endfunction
    function automatic logic [COL_W-1:0] e_srh();
        return (LAT == 2) ? o_srh : s1_srh();
    endfunction
    function automatic logic [COL_W-1:0] e_ref();
        return (LAT == 2) ? o_ref : s1_ref();
    endfunction
    function automatic logic e_valid();
        return (LAT == 2) ? o_valid : m_valid;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist = {};
            for (int k = 0; k < REG_NUM; k++) hist.push_back('0);
            m_fill = 0; m_valid = 1'b0; m_err = 1'b0;
            o_total = '0; o_srh = '0; o_ref = '0; o_valid = 1'b0;
        end else begin
            o_total = s1_total(); o_srh = s1_srh(); o_ref = s1_ref(); o_valid = m_valid;
            if (sof_i) m_err = 1'b0;
            m_valid = 1'b0;
            if (valid_i) begin
                if (int'(head_num_i) >= NUM_LINES) m_err = 1'b1;
                hist.push_front(rotate(data_i, (int'(head_num_i) >= NUM_LINES) ? 0 : int'(head_num_i)));
                void'(hist.pop_back());
                m_fill  = sof_i ? 1 : m_fill + 1;
                m_valid = (m_fill >= REG_NUM);
            end else if (sof_i) begin
                m_fill = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_valid", COL_W'(valid_o), COL_W'(e_valid()));
            chk("cyc_err",   COL_W'(head_err_o), COL_W'(m_err));
            chk("cyc_total", total_blk_o, e_total());
            chk("cyc_srh",   COL_W'(srh_blk_o), e_srh());
            chk("cyc_ref",   COL_W'(ref_blk_o), e_ref());
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [IN_W-1:0] pat(input int base);
        logic [IN_W-1:0] d;
        for (int j = 0; j < NUM_LINES; j++) d[j*DW +: DW] = DW'(base + j);
        return d;
    endfunction

    function automatic logic [IN_W-1:0] rnd_data();
        logic [IN_W-1:0] d;
        for (int j = 0; j < NUM_LINES; j++) d[j*DW +: DW] = DW'($urandom_range(0, 4095));
        return d;
    endfunction

    task automatic drive(input logic v, input logic s, input int h, input logic [IN_W-1:0] d);
        @(negedge clk);
        valid_i = v; sof_i = s; head_num_i = HEAD_WIDTH'(h); data_i = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 0, '0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, COL_W'(valid_o), '0);
        chk({tag, "_err"},   COL_W'(head_err_o), '0);
        chk({tag, "_total"}, total_blk_o, '0);
        chk({tag, "_srh"},   COL_W'(srh_blk_o), '0);
        chk({tag, "_ref"},   COL_W'(ref_blk_o), '0);
    endtask

    initial begin
        int cnt;
        logic [COL_W-1:0] t;
        valid_i = 1'b0; sof_i = 1'b0; head_num_i = '0; data_i = '0; rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 chk_zero("reset");
        @(negedge clk);
        #2 rst_n = 1'b1;
        chk_en = 1'b1;

        // Beat b carries line j = j + 16*b, head 0.
        for (int b = 1; b <= 7; b++) drive(1'b1, 1'b0, 0, pat(16*b));
        repeat (LAT) idle();
        chk("t1_valid",     COL_W'(valid_o), 1);
        chk("t1_total_r0",  COL_W'(total_blk_o[0 +: DW]), 16);
        chk("t1_total_r16", COL_W'(total_blk_o[16*DW +: DW]), 32);
        chk("t1_srh_r0",    COL_W'(srh_blk_o[0 +: DW]), 50);
        chk("t1_srh_r12",   COL_W'(srh_blk_o[12*DW +: DW]), 62);
        chk("t1_ref_r0",    COL_W'(ref_blk_o[0 +: DW]), 118);
        chk("t1_ref_r4",    COL_W'(ref_blk_o[4*DW +: DW]), 122);
        t = e_total();
        chk("t1_model_total_r0", COL_W'(t[0 +: DW]), 16);
        t = e_ref();
        chk("t1_model_ref_r0",   COL_W'(t[0 +: DW]), 118);

        // Head 15, line j = j: rows 15,16,17,0,1,...,13.
        drive(1'b1, 1'b1, 15, pat(0));
        for (int b = 2; b <= 7; b++) drive(1'b1, 1'b0, 15, pat(0));
        repeat (LAT) idle();
        chk("t2_valid",     COL_W'(valid_o), 1);
        chk("t2_total_r0",  COL_W'(total_blk_o[0 +: DW]), 15);
        chk("t2_total_r2",  COL_W'(total_blk_o[2*DW +: DW]), 17);
        chk("t2_total_r3",  COL_W'(total_blk_o[3*DW +: DW]), 0);
        chk("t2_total_r16", COL_W'(total_blk_o[16*DW +: DW]), 13);
        chk("t2_ref_r0",    COL_W'(ref_blk_o[0 +: DW]), 3);
        t = e_total();
        chk("t2_model_total_r3", COL_W'(t[3*DW +: DW]), 0);

        // Ten beats separated by two idle cycles: four valid pulses.
        drive(1'b0, 1'b1, 0, '0);
        cnt = 0;
        for (int b = 1; b <= 10; b++) begin
            drive(1'b1, 1'b0, $urandom_range(0, NUM_LINES-1), rnd_data());
            repeat (2) begin
                idle();
                if (valid_o) cnt++;
            end
        end
        chk("t3_gap_valid_count", COL_W'(cnt), 4);

        // sof alone: six beats give no valid, the seventh does.
        drive(1'b0, 1'b1, 0, '0);
        cnt = 0;
        for (int b = 1; b <= 6; b++) begin
            drive(1'b1, 1'b0, $urandom_range(0, NUM_LINES-1), rnd_data());
            if (valid_o) cnt++;
        end
        repeat (LAT) begin
            idle();
            if (valid_o) cnt++;
        end
        chk("t4_no_valid_before_7", COL_W'(cnt), 0);
        drive(1'b1, 1'b0, 3, rnd_data());
        repeat (LAT) idle();
        chk("t4_valid_at_7", COL_W'(valid_o), 1);

        // sof with valid counts as the first beat.
        drive(1'b1, 1'b1, 2, rnd_data());
        for (int b = 2; b <= 6; b++) drive(1'b1, 1'b0, 2, rnd_data());
        repeat (LAT) idle();
        chk("t5_valid_after_6", COL_W'(valid_o), 0);
        drive(1'b1, 1'b0, 2, rnd_data());
        repeat (LAT) idle();
        chk("t5_valid_after_7", COL_W'(valid_o), 1);

        // Out-of-range head together with sof: set wins, rotation as head 0.
        drive(1'b1, 1'b1, 20, pat(100));
        idle();
        chk("t6_err_rise", COL_W'(head_err_o), 1);
        if (LAT == 2) idle();
        chk("t6_ref_r0", COL_W'(ref_blk_o[0 +: DW]), 106);
        repeat (5) idle();
        chk("t6_err_sticky", COL_W'(head_err_o), 1);
        drive(1'b0, 1'b1, 0, '0);
        idle();
        chk("t6_err_clear", COL_W'(head_err_o), 0);

        // Reset in the middle of a sweep, after beat 4.
        drive(1'b0, 1'b1, 0, '0);
        for (int b = 1; b <= 4; b++) drive(1'b1, 1'b0, $urandom_range(0, 19), rnd_data());
        idle();
        #2 rst_n = 1'b0;
        #1 chk_zero("midrst");
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int b = 1; b <= 6; b++) drive(1'b1, 1'b0, 5, rnd_data());
        repeat (LAT) idle();
        chk("t7_valid_after_6", COL_W'(valid_o), 0);
        drive(1'b1, 1'b0, 5, rnd_data());
        repeat (LAT) idle();
        chk("t7_valid_after_7", COL_W'(valid_o), 1);

        // Randomised traffic, including occasional bad heads and sof.
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0,
                  $urandom_range(0, 19), rnd_data());
        end
        repeat (3) idle();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
